// File: rtl/multicycle_data_mem_responder.sv
// Slow word-wide data memory for the multicycle CPU load/store path.
// One req/ack transaction at a time, fixed wait states, err on misaligned/out-of-range access.
//
//   state  | meaning
//   S_IDLE | ready; req accepted on the next edge
//   S_WAIT | request latched, counting down wait states
//   S_RESP | ack (and err if rejected) high for this one cycle
module multicycle_data_mem_responder #(
    parameter int          DEPTH_BYTES = 128,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy
);

    localparam int          AW       = $clog2(DEPTH_BYTES);
    localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam logic [31:0] LAST_OFS = 32'(DEPTH_BYTES - 4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    cnt;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          err_q;
    logic [7:0]    m [DEPTH_BYTES];

    logic          commit;
    logic          acc_we;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [31:0]   ofs;
    logic          acc_err;
    logic [AW-3:0] idx_hi;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req) state_nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            S_WAIT:  if (cnt == 4'd0) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // With zero wait states the commit edge is the accept edge, so take the live inputs.
    always_comb begin
        acc_we    = (state == S_IDLE) ? we    : we_q;
        acc_addr  = (state == S_IDLE) ? addr  : addr_q;
        acc_wdata = (state == S_IDLE) ? wdata : wdata_q;
        ofs       = acc_addr - BASE_ADDR;
        acc_err   = (acc_addr[1:0] != 2'b00) || (ofs > LAST_OFS);
        idx_hi    = ofs[AW-1:2];
        commit    = reset && (state_nxt == S_RESP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
            rdata   <= 32'h0;
        end else begin
            if (state == S_IDLE && req) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
                cnt     <= CNT_LOAD;
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                err_q <= acc_err;
                if (!acc_we && !acc_err) begin
                    rdata <= {m[{idx_hi, 2'd0}], m[{idx_hi, 2'd1}],
                              m[{idx_hi, 2'd2}], m[{idx_hi, 2'd3}]};
                end
            end
        end
    end

    // Storage survives reset; big-endian byte placement.
    always_ff @(posedge clk) begin
        if (commit && acc_we && !acc_err) begin
            m[{idx_hi, 2'd0}] <= acc_wdata[31:24];
            m[{idx_hi, 2'd1}] <= acc_wdata[23:16];
            m[{idx_hi, 2'd2}] <= acc_wdata[15:8];
            m[{idx_hi, 2'd3}] <= acc_wdata[7:0];
        end
    end

    assign ack  = (state == S_RESP);
    assign err  = (state == S_RESP) && err_q;
    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_multicycle_data_mem_responder.sv
// Directed bench for multicycle_data_mem_responder: a 2-wait-state instance (index 0)
// and a zero-wait-state instance (index 1) driven by the same transaction task.
module tb_multicycle_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n2;
    logic        rst_n0;
    logic        req_v   [2];
    logic        we_v    [2];
    logic [31:0] addr_v  [2];
    logic [31:0] wdata_v [2];
    logic [31:0] rdata_v [2];
    logic        ack_v   [2];
    logic        err_v   [2];
    logic        busy_v  [2];

    int n_tests    = 0;
    int n_fail     = 0;
    int err_glitch = 0;

    always #5 clk = ~clk;

    multicycle_data_mem_responder #(
        .DEPTH_BYTES(128), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)
    ) u_w2 (
        .clk(clk), .reset(rst_n2), .req(req_v[0]), .we(we_v[0]),
        .addr(addr_v[0]), .wdata(wdata_v[0]), .rdata(rdata_v[0]),
        .ack(ack_v[0]), .err(err_v[0]), .busy(busy_v[0])
    );

    multicycle_data_mem_responder #(
        .DEPTH_BYTES(128), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)
    ) u_w0 (
        .clk(clk), .reset(rst_n0), .req(req_v[1]), .we(we_v[1]),
        .addr(addr_v[1]), .wdata(wdata_v[1]), .rdata(rdata_v[1]),
        .ack(ack_v[1]), .err(err_v[1]), .busy(busy_v[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // lat = edges after the accept edge at which ack is seen (-1 if never).
    task automatic xfer(input int u, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic scramble, output int lat, output int bc,
                        output logic e, output logic [31:0] rd);
        lat = -1;
        bc  = 0;
        e   = 1'b0;
        rd  = 32'hDEAD_DEAD;
        req_v[u]   = 1'b1;
        we_v[u]    = w;
        addr_v[u]  = a;
        wdata_v[u] = d;
        for (int k = 0; k < 24; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                req_v[u] = 1'b0;
                if (scramble) begin
                    we_v[u]    = ~w;
                    addr_v[u]  = 32'h10;
                    wdata_v[u] = 32'h0;
                end
            end
            if (busy_v[u]) bc++;
            if (!ack_v[u] && err_v[u]) err_glitch++;
            if (ack_v[u] && lat < 0) begin
                lat = k;
                e   = err_v[u];
                rd  = rdata_v[u];
            end
            if (!busy_v[u]) break;
        end
    endtask

    initial begin
        int          lat;
        int          bc;
        logic        e;
        logic [31:0] rd;
        int          a1;
        int          a2;
        logic        b3;
        int          acks_seen;

        for (int i = 0; i < 2; i++) begin
            req_v[i]   = 1'b0;
            we_v[i]    = 1'b0;
            addr_v[i]  = 32'h0;
            wdata_v[i] = 32'h0;
        end
        rst_n2 = 1'b0;
        rst_n0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack",   32'(ack_v[0]),  32'h0);
        check("rst_err",   32'(err_v[0]),  32'h0);
        check("rst_busy",  32'(busy_v[0]), 32'h0);
        check("rst_rdata", rdata_v[0],     32'h0);
        check("rst_busy0", 32'(busy_v[1]), 32'h0);
        rst_n2 = 1'b1;
        rst_n0 = 1'b1;
        @(posedge clk);
        #1;

        xfer(0, 1'b1, 32'h10, 32'h1234_5678, 1'b0, lat, bc, e, rd);
        check("wr10_lat",  32'(lat), 32'd2);
        check("wr10_err",  32'(e),   32'h0);
        check("wr10_busy", 32'(bc),  32'd3);
        xfer(0, 1'b0, 32'h10, 32'h0, 1'b0, lat, bc, e, rd);
        check("rd10_lat",  32'(lat), 32'd2);
        check("rd10_err",  32'(e),   32'h0);
        check("rd10_data", rd,       32'h1234_5678);
        check("rd10_busy", 32'(bc),  32'd3);
        check("peek_m10",  32'(u_w2.m[16]), 32'h12);
        check("peek_m11",  32'(u_w2.m[17]), 32'h34);
        check("peek_m13",  32'(u_w2.m[19]), 32'h78);

        xfer(0, 1'b1, 32'h7C, 32'hAABB_CCDD, 1'b0, lat, bc, e, rd);
        check("wr7c_err",  32'(e), 32'h0);
        xfer(0, 1'b0, 32'h7C, 32'h0, 1'b0, lat, bc, e, rd);
        check("rd7c_err",  32'(e), 32'h0);
        check("rd7c_data", rd,     32'hAABB_CCDD);
        xfer(0, 1'b1, 32'h00, 32'h0102_0304, 1'b0, lat, bc, e, rd);
        check("wr00_err",  32'(e), 32'h0);
        xfer(0, 1'b0, 32'h10, 32'h0, 1'b0, lat, bc, e, rd);
        check("rd10b_data", rd, 32'h1234_5678);

        xfer(0, 1'b1, 32'h13, 32'hDEAD_BEEF, 1'b0, lat, bc, e, rd);
        check("wr13_lat", 32'(lat), 32'd2);
        check("wr13_err", 32'(e),   32'h1);
        xfer(0, 1'b1, 32'h80, 32'hCAFE_F00D, 1'b0, lat, bc, e, rd);
        check("wr80_err", 32'(e),   32'h1);
        xfer(0, 1'b0, 32'h80, 32'h0, 1'b0, lat, bc, e, rd);
        check("rd80_err",  32'(e), 32'h1);
        check("rd80_kept", rd,     32'h1234_5678);
        check("rd80_hold", rdata_v[0], 32'h1234_5678);
        xfer(0, 1'b0, 32'h10, 32'h0, 1'b0, lat, bc, e, rd);
        check("rd10_after_err", rd, 32'h1234_5678);
        xfer(0, 1'b0, 32'h00, 32'h0, 1'b0, lat, bc, e, rd);
        check("rd00_no_wrap", rd, 32'h0102_0304);

        req_v[0]   = 1'b1;
        we_v[0]    = 1'b1;
        addr_v[0]  = 32'h10;
        wdata_v[0] = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        req_v[0] = 1'b0;
        check("rstw_busy_pre", 32'(busy_v[0]), 32'h1);
        @(posedge clk);
        #1;
        rst_n2 = 1'b0;
        #1;
        check("rstw_busy_async", 32'(busy_v[0]), 32'h0);
        check("rstw_ack_async",  32'(ack_v[0]),  32'h0);
        acks_seen = 0;
        @(posedge clk);
        #1;
        if (ack_v[0]) acks_seen++;
        rst_n2 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (ack_v[0]) acks_seen++;
        end
        check("rstw_no_ack", 32'(acks_seen), 32'h0);
        xfer(0, 1'b0, 32'h10, 32'h0, 1'b0, lat, bc, e, rd);
        check("rstw_no_write", rd, 32'h1234_5678);

        xfer(0, 1'b1, 32'h20, 32'h5A5A_5A5A, 1'b1, lat, bc, e, rd);
        check("scr_lat", 32'(lat), 32'd2);
        check("scr_err", 32'(e),   32'h0);
        xfer(0, 1'b0, 32'h20, 32'h0, 1'b0, lat, bc, e, rd);
        check("scr_rd20", rd, 32'h5A5A_5A5A);
        xfer(0, 1'b0, 32'h10, 32'h0, 1'b0, lat, bc, e, rd);
        check("scr_rd10", rd, 32'h1234_5678);

        a1 = -1;
        a2 = -1;
        b3 = 1'bx;
        req_v[0]  = 1'b1;
        we_v[0]   = 1'b0;
        addr_v[0] = 32'h7C;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (ack_v[0]) begin
                if (a1 < 0) a1 = k;
                else if (a2 < 0) a2 = k;
            end
            if (k == 3) b3 = busy_v[0];
        end
        req_v[0] = 1'b0;
        check("hold_ack1",   32'(a1), 32'd2);
        check("hold_ack2",   32'(a2), 32'd6);
        check("hold_gap",    32'(b3), 32'h0);
        check("hold_rdata",  rdata_v[0], 32'hAABB_CCDD);
        for (int k = 0; k < 8 && busy_v[0]; k++) begin
            @(posedge clk);
            #1;
        end
        check("hold_idle", 32'(busy_v[0]), 32'h0);

        xfer(1, 1'b1, 32'h10, 32'h0BAD_F00D, 1'b0, lat, bc, e, rd);
        check("w0_wr_lat",  32'(lat), 32'd0);
        check("w0_wr_busy", 32'(bc),  32'd1);
        check("w0_wr_err",  32'(e),   32'h0);
        xfer(1, 1'b0, 32'h10, 32'h0, 1'b0, lat, bc, e, rd);
        check("w0_rd_lat",  32'(lat), 32'd0);
        check("w0_rd_data", rd,       32'h0BAD_F00D);
        xfer(1, 1'b0, 32'h12, 32'h0, 1'b0, lat, bc, e, rd);
        check("w0_mis_err", 32'(e),   32'h1);
        check("w0_mis_kept", rd,      32'h0BAD_F00D);

        check("err_without_ack", 32'(err_glitch), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
